// File: rtl/fxp_div_seq.sv
// Sequential signed Q5.11 divider.
// Radix-2 restoring loop over magnitudes, one quotient bit per clock.
module fxp_div_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW);

  localparam logic [NW-1:0] MAG_POS = NW'((1 << (WIDTH-1)) - 1);
  localparam logic [NW-1:0] MAG_NEG = NW'(1 << (WIDTH-1));
  localparam logic [WIDTH-1:0] Q_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic             zdiv_q, zdiv_d;
  logic             dneg_q, dneg_d;
  logic [NW-1:0]    num_q, num_d;
  logic [NW-1:0]    qmag_q, qmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             take;

  // Magnitudes as unsigned words; the most negative value maps to 2^(W-1).
  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign dsr_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;

  // The shifted remainder needs one extra bit; after a subtract it fits again.
  assign rem_sh  = {rem_q, num_q[NW-1]};
  assign take    = (rem_sh >= {1'b0, dsr_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dsr_q;

  // Next-state, datapath and output-register logic of the divider FSM.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    zdiv_d  = zdiv_q;
    dneg_d  = dneg_q;
    num_d   = num_q;
    qmag_d  = qmag_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          sign_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          zdiv_d  = (divisor == '0);
          dneg_d  = dividend[WIDTH-1];
          num_d   = {dvd_mag, {FRAC{1'b0}}};
          qmag_d  = '0;
          rem_d   = '0;
          dsr_d   = dsr_mag;
          cnt_d   = CW'(NW - 1);
          state_d = (divisor == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d  = take ? rem_sub : rem_sh[WIDTH-1:0];
        num_d  = {num_q[NW-2:0], 1'b0};
        qmag_d = {qmag_q[NW-2:0], take};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        if (zdiv_q) begin
          quo_d = dneg_q ? Q_NEG : Q_POS;
          dz_d  = 1'b1;
        end else if (!sign_q) begin
          if (qmag_q > MAG_POS) begin
            quo_d = Q_POS;
            ovf_d = 1'b1;
          end else begin
            quo_d = qmag_q[WIDTH-1:0];
          end
        end else begin
          if (qmag_q > MAG_NEG) begin
            quo_d = Q_NEG;
            ovf_d = 1'b1;
          end else begin
            quo_d = ~qmag_q[WIDTH-1:0] + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      dneg_q  <= 1'b0;
      num_q   <= '0;
      qmag_q  <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      zdiv_q  <= zdiv_d;
      dneg_q  <= dneg_d;
      num_q   <= num_d;
      qmag_q  <= qmag_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dz_q;

endmodule
